// File: rtl/player_motion_ctrl.sv
// Per-frame player motion controller: decodes WASD-style keys, runs a
// ground/rise/fall state machine and emits registered step outputs.
module player_motion_ctrl #(
  parameter int unsigned JUMP_V   = 10,
  parameter int unsigned MAX_FALL = 4,
  parameter int unsigned GRAV_DIV = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode [6],
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic       mv_left,
  output logic       mv_right,
  output logic [9:0] rise_step,
  output logic [9:0] fall_step,
  output logic [1:0] state
);

  localparam int unsigned RW = $clog2(JUMP_V + 1);
  localparam int unsigned FW = $clog2(MAX_FALL + 1);
  localparam int unsigned GW = (GRAV_DIV > 1) ? $clog2(GRAV_DIV) : 1;

  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_RISE   = 2'b01,
    ST_FALL   = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   rise_v_q, rise_v_d;
  logic [FW-1:0]   fall_v_q, fall_v_d;
  logic [GW-1:0]   grav_cnt_q, grav_cnt_d;
  logic            key_j_prev_q;
  logic            mv_left_q, mv_left_d;
  logic            mv_right_q, mv_right_d;
  logic [9:0]      rise_step_q, rise_step_d;
  logic [9:0]      fall_step_q, fall_step_d;

  logic [5:0] hit_l, hit_r, hit_j;
  logic       key_l, key_r, key_j, jump_edge;

  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_key_dec
      assign hit_l[gi] = (keycode[gi] == 8'h04);
      assign hit_r[gi] = (keycode[gi] == 8'h07);
      assign hit_j[gi] = (keycode[gi] == 8'h1A);
    end
  endgenerate

  assign key_l     = |hit_l;
  assign key_r     = |hit_r;
  assign key_j     = |hit_j;
  assign jump_edge = key_j & ~key_j_prev_q;

  always_comb begin
    state_d    = state_q;
    rise_v_d   = rise_v_q;
    fall_v_d   = fall_v_q;
    grav_cnt_d = grav_cnt_q;
    mv_left_d  = key_l & ~key_r & ~left;
    mv_right_d = key_r & ~key_l & ~right;

    unique case (state_q)
      ST_GROUND: begin
        if (!down) begin
          state_d    = ST_FALL;
          fall_v_d   = FW'(1);
          grav_cnt_d = '0;
        end else if (jump_edge && !up) begin
          state_d  = ST_RISE;
          rise_v_d = RW'(JUMP_V);
        end
      end
      ST_RISE: begin
        // A head bump wins over the natural apex, both hand over to FALL.
        if (up || (rise_v_q == RW'(1))) begin
          state_d    = ST_FALL;
          rise_v_d   = '0;
          fall_v_d   = FW'(1);
          grav_cnt_d = '0;
        end else begin
          rise_v_d = rise_v_q - RW'(1);
        end
      end
      ST_FALL: begin
        if (down) begin
          state_d    = ST_GROUND;
          fall_v_d   = '0;
          grav_cnt_d = '0;
        end else if (grav_cnt_q == GW'(GRAV_DIV - 1)) begin
          grav_cnt_d = '0;
          if (fall_v_q != FW'(MAX_FALL)) begin
            fall_v_d = fall_v_q + FW'(1);
          end
        end else begin
          grav_cnt_d = grav_cnt_q + GW'(1);
        end
      end
      default: begin
        state_d    = ST_GROUND;
        rise_v_d   = '0;
        fall_v_d   = '0;
        grav_cnt_d = '0;
      end
    endcase

    // Steps reflect the state being entered, so they line up with state.
    rise_step_d = (state_d == ST_RISE) ? 10'(rise_v_d) : 10'd0;
    fall_step_d = (state_d == ST_FALL) ? 10'(fall_v_d) : 10'd0;
  end

  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q      <= ST_GROUND;
      rise_v_q     <= '0;
      fall_v_q     <= '0;
      grav_cnt_q   <= '0;
      key_j_prev_q <= 1'b1;
      mv_left_q    <= 1'b0;
      mv_right_q   <= 1'b0;
      rise_step_q  <= 10'd0;
      fall_step_q  <= 10'd0;
    end else begin
      state_q      <= state_d;
      rise_v_q     <= rise_v_d;
      fall_v_q     <= fall_v_d;
      grav_cnt_q   <= grav_cnt_d;
      key_j_prev_q <= key_j;
      mv_left_q    <= mv_left_d;
      mv_right_q   <= mv_right_d;
      rise_step_q  <= rise_step_d;
      fall_step_q  <= fall_step_d;
    end
  end

  assign state     = state_q;
  assign mv_left   = mv_left_q;
  assign mv_right  = mv_right_q;
  assign rise_step = rise_step_q;
  assign fall_step = fall_step_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Directed and randomized bench for player_motion_ctrl against a
// frame-counting behavioural model.
module tb_player_motion_ctrl;

  localparam int JUMP_V   = 10;
  localparam int MAX_FALL = 4;
  localparam int GRAV_DIV = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] kc [6];
  logic       up_s, dn, lft, rgt;
  logic       mv_left, mv_right;
  logic [9:0] rise_step, fall_step;
  logic [1:0] state;

  int n_assert = 0;
  int n_fail   = 0;
  int frame_no = 0;

  // Model: mode 0 ground, 1 rise, 2 fall; fall speed derived from frames spent falling.
  int m_mode, m_rise, m_ff;
  bit m_prevj, m_ml, m_mr;

  player_motion_ctrl #(.JUMP_V(JUMP_V), .MAX_FALL(MAX_FALL), .GRAV_DIV(GRAV_DIV)) dut (
    .frame_clk (clk),
    .Reset     (rst),
    .keycode   (kc),
    .up        (up_s),
    .down      (dn),
    .left      (lft),
    .right     (rgt),
    .mv_left   (mv_left),
    .mv_right  (mv_right),
    .rise_step (rise_step),
    .fall_step (fall_step),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (frame %0d)", tag, obs, exp, frame_no);
    end
  endtask

  task automatic model_update();
    bit kl, kr, kj, jedge;
    if (rst) begin
      m_mode = 0; m_rise = 0; m_ff = 0; m_prevj = 1; m_ml = 0; m_mr = 0;
      return;
    end
    kl = 0; kr = 0; kj = 0;
    for (int i = 0; i < 6; i++) begin
      kl |= (kc[i] == 8'h04);
      kr |= (kc[i] == 8'h07);
      kj |= (kc[i] == 8'h1A);
    end
    jedge   = kj && !m_prevj;
    m_prevj = kj;
    m_ml    = kl && !kr && !lft;
    m_mr    = kr && !kl && !rgt;
    case (m_mode)
      0: if (!dn) begin m_mode = 2; m_ff = 0; end
         else if (jedge && !up_s) begin m_mode = 1; m_rise = JUMP_V; end
      1: if (up_s || m_rise == 1) begin m_mode = 2; m_ff = 0; end
         else m_rise--;
      default: if (dn) m_mode = 0; else m_ff++;
    endcase
  endtask

  task automatic check_all();
    int ef, er;
    er = (m_mode == 1) ? m_rise : 0;
    ef = (m_mode == 2) ? ((1 + m_ff / GRAV_DIV) < MAX_FALL ? 1 + m_ff / GRAV_DIV : MAX_FALL) : 0;
    chk("state", 32'(state), 32'(m_mode));
    chk("mv_left", 32'(mv_left), 32'(m_ml));
    chk("mv_right", 32'(mv_right), 32'(m_mr));
    chk("rise_step", 32'(rise_step), 32'(er));
    chk("fall_step", 32'(fall_step), 32'(ef));
    chk("steps_exclusive", 32'(rise_step != 0 && fall_step != 0), 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    frame_no++;
    $display("frame %0d rst=%0d dn=%0d up=%0d -> st=%0d rs=%0d fs=%0d ml=%0d mr=%0d",
             frame_no, rst, dn, up_s, state, rise_step, fall_step, mv_left, mv_right);
    check_all();
  endtask

  task automatic clear_keys();
    for (int i = 0; i < 6; i++) kc[i] = 8'h00;
  endtask

  int exp_fall [20] = '{1,1,1,1,2,2,2,2,3,3,3,3,4,4,4,4,4,4,4,4};

  initial begin
    clear_keys();
    rst = 1; up_s = 0; dn = 1; lft = 0; rgt = 0;
    kc[0] = 8'h1A;
    step(); step();
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_fall", 32'(fall_step), 32'd0);

    // W held across reset must not jump.
    rst = 0;
    step(); step();
    chk("no_jump_after_reset", 32'(state), 32'd0);
    kc[0] = 8'h00; step();
    kc[0] = 8'h1A; step();
    chk("jump_start", 32'(rise_step), 32'd10);
    for (int k = 9; k >= 1; k--) begin
      step();
      chk("rise_seq", 32'(rise_step), 32'(k));
    end
    step();
    chk("apex_state", 32'(state), 32'd2);
    chk("apex_fall", 32'(fall_step), 32'd1);
    step(); step(); step();
    chk("no_rejump_held", 32'(state), 32'd0);

    // Head bump at rise_step 7.
    kc[0] = 8'h00; step();
    kc[0] = 8'h1A; step(); step(); step(); step();
    chk("rise_is_7", 32'(rise_step), 32'd7);
    up_s = 1; step(); up_s = 0;
    chk("bump_rise", 32'(rise_step), 32'd0);
    chk("bump_fall", 32'(fall_step), 32'd1);
    chk("bump_state", 32'(state), 32'd2);
    step();
    chk("bump_land", 32'(state), 32'd0);

    // Head bump coinciding with the last rise frame.
    kc[0] = 8'h00; step();
    kc[0] = 8'h1A; step();
    for (int k = 0; k < 9; k++) step();
    chk("rise_is_1", 32'(rise_step), 32'd1);
    up_s = 1; step(); up_s = 0;
    chk("bump_apex_rise", 32'(rise_step), 32'd0);
    chk("bump_apex_fall", 32'(fall_step), 32'd1);
    step();

    // Jump blocked by a ceiling while grounded.
    kc[0] = 8'h00; step();
    up_s = 1; kc[0] = 8'h1A; step(); up_s = 0;
    chk("ceiling_blocks_jump", 32'(state), 32'd0);

    // Free fall gravity profile, then landing with a simultaneous jump press.
    kc[0] = 8'h00; dn = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("fall_seq", 32'(fall_step), 32'(exp_fall[i]));
    end
    dn = 1; kc[2] = 8'h1A; step();
    chk("land_state", 32'(state), 32'd0);
    chk("land_fall", 32'(fall_step), 32'd0);
    step();
    chk("land_jump_ignored", 32'(state), 32'd0);
    clear_keys();

    // Horizontal movement.
    kc[0] = 8'h04; kc[1] = 8'h07; step();
    chk("both_keys_l", 32'(mv_left), 32'd0);
    chk("both_keys_r", 32'(mv_right), 32'd0);
    clear_keys(); kc[5] = 8'h04; step();
    chk("left_slot5", 32'(mv_left), 32'd1);
    clear_keys(); kc[3] = 8'h07; rgt = 1; step();
    chk("right_blocked", 32'(mv_right), 32'd0);
    rgt = 0; step();
    chk("right_free", 32'(mv_right), 32'd1);
    clear_keys(); kc[4] = 8'h04; dn = 0; step(); step();
    chk("left_in_fall", 32'(mv_left), 32'd1);
    chk("left_in_fall_state", 32'(state), 32'd2);
    rst = 1; step(); rst = 0;
    chk("reset_mid_fall", 32'(state), 32'd0);
    dn = 1; clear_keys(); step();

    // Reset mid-rise with W held.
    kc[1] = 8'h1A; step(); step();
    chk("pre_reset_rise", 32'(state), 32'd1);
    rst = 1; step(); rst = 0;
    chk("reset_mid_rise", 32'(state), 32'd0);
    chk("reset_mid_rise_rs", 32'(rise_step), 32'd0);
    step(); step();
    chk("held_no_jump", 32'(state), 32'd0);
    kc[1] = 8'h00; step();
    kc[1] = 8'h1A; step();
    chk("repress_jump", 32'(state), 32'd1);

    // Randomized frames.
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0, 1: kc[$urandom_range(0, 5)] = 8'h00;
          2:    kc[$urandom_range(0, 5)] = 8'h04;
          3:    kc[$urandom_range(0, 5)] = 8'h07;
          4:    kc[$urandom_range(0, 5)] = 8'h1A;
          default: kc[$urandom_range(0, 5)] = 8'($urandom_range(0, 255));
        endcase
      end
      if ($urandom_range(0, 7) == 0) dn = ~dn;
      up_s = ($urandom_range(0, 11) == 0);
      lft  = ($urandom_range(0, 3) == 0);
      rgt  = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 63) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/player_motion_ctrl.md
PLAYER_MOTION_CTRL -- requirements
Module: player_motion_ctrl

Interface
REQ-001 Parameter JUMP_V, 10: initial rise step in pixels per frame at jump start.
REQ-002 Parameter MAX_FALL, 4: saturation value of fall step.
REQ-003 Parameter GRAV_DIV, 4: frames per fall-step increment.
REQ-004 Port frame_clk, input, 1: sole clock, one edge per video frame.
REQ-005 Port Reset, input, 1: synchronous, active-high reset.
REQ-006 Port keycode, input, 6x8: unpacked array [6] of USB HID keycodes; 8'h00 means empty slot.
REQ-007 Port up, input, 1: collision above the player.
REQ-008 Port down, input, 1: collision below the player (on floor).
REQ-009 Port left, input, 1: collision on the left.
REQ-010 Port right, input, 1: collision on the right.
REQ-011 Port mv_left, output, 1: move X by -1 this frame.
REQ-012 Port mv_right, output, 1: move X by +1 this frame.
REQ-013 Port rise_step, output, 10: pixels to subtract from Y this frame.
REQ-014 Port fall_step, output, 10: pixels to add to Y this frame.
REQ-015 Port state, output, 2: 2'b00 GROUND, 2'b01 RISE, 2'b10 FALL; 2'b11 is never driven.

Function
REQ-016 All outputs shall be registered; inputs sampled at edge N shall determine outputs valid after edge N.
REQ-017 Key decode shall check all six keycode slots: key_l = any slot == 8'h04 (A), key_r = any slot == 8'h07 (D), key_j = any slot == 8'h1A (W).
REQ-018 mv_left shall be key_l & ~key_r & ~left; mv_right shall be key_r & ~key_l & ~right; both keys held shall give no movement.
REQ-019 A jump edge shall be key_j high with key_j low at the previous edge (registered key_j_prev); holding W shall not re-trigger.
REQ-020 Internal counters shall be rise_v (4 bits, 0..JUMP_V), fall_v (0..MAX_FALL), and grav_cnt (0..GRAV_DIV-1).
REQ-021 GROUND transitions:
- if ~down: go to FALL with fall_v = 1 and grav_cnt = 0;
- else if jump edge & ~up: go to RISE with rise_v = JUMP_V;
- otherwise stay.
- rise_step = 0 and fall_step = 0 in GROUND.
REQ-022 RISE outputs: rise_step = rise_v and fall_step = 0.
REQ-023 RISE transitions:
- rise_v decrements each frame;
- if up: go to FALL with fall_v = 1 and rise_step forced to 0;
- if rise_v == 1: go to FALL with fall_v = 1 after outputting rise_step = 1.
REQ-024 RISE shall ignore jump edges and the down input.
REQ-025 FALL outputs: fall_step = fall_v and rise_step = 0.
REQ-026 FALL shall advance grav_cnt each frame; on wrap from GRAV_DIV-1 to 0, fall_v increments, saturating at MAX_FALL.
REQ-027 FALL shall go to GROUND when down is high, with fall_step = 0 that same update; a jump edge in that frame shall be ignored.
REQ-028 In RISE, simultaneous up and rise_v == 1 shall give the up behaviour: FALL with rise_step = 0.
REQ-029 Horizontal movement shall be independent of the FSM state and allowed in every state.
REQ-030 Arithmetic shall be unsigned.
REQ-031 rise_step and fall_step shall be zero-extended to 10 bits.
REQ-032 rise_step and fall_step shall never both be nonzero.

Reset
REQ-033 While Reset is high at an edge: state = GROUND, mv_left = mv_right = 0, rise_step = fall_step = 0, rise_v = fall_v = grav_cnt = 0, key_j_prev = 1.
REQ-034 Because key_j_prev resets to 1, W held across reset shall not jump.
REQ-035 Reset asserted mid-RISE or mid-FALL shall abort the jump or fall within the same edge.

Verification
REQ-036 down = 1, keycode = {04,07,0,0,0,0} -> mv_left = mv_right = 0; keycode = {0,0,0,0,0,04} -> mv_left = 1 next edge.
REQ-037 down = 1, W pressed and held -> state = RISE; rise_step sequence 10,9,...,1, then state = FALL with fall_step = 1; no second jump while held.
REQ-038 In RISE with rise_step = 7, assert up for one frame -> next outputs rise_step = 0, fall_step = 1, state = FALL.
REQ-039 down = 0 from GROUND for 20 frames -> fall_step = 1,1,1,1,2,2,2,2,3,3,3,3,4,4,... holding at 4; assert down -> state = GROUND, fall_step = 0.
REQ-040 key D with right = 1 -> mv_right = 0; during FALL, key A with left = 0 -> mv_left = 1.
REQ-041 Reset for one edge mid-RISE with W held -> all outputs 0, state = GROUND; no jump until W is released and pressed again.
